// File: rtl/rob_multiport.sv
// rob_multiport: parametrised reorder buffer with multiple write-back ports.
//
// Entries are allocated in program order at the tail on issue, marked ready
// by write-back channels (or at issue), and retired in order from the head.
// Register results go to the register file, stores are handed to the LSB via
// a held request/acknowledge pair, and a mispredicted branch retires into a
// one-cycle registered flush that empties the whole buffer.
//
// Ports:
//   clk_in, rst_n_in, rdy_in          clock, async active-low reset, global ready
//   iss_valid/ready/type/value/rd     issue request from the decoder
//   iss_idx                           tag assigned to the issuing entry (tail)
//   full, empty, count                occupancy status
//   q_idx1/2 -> q_ready1/2, q_value1/2  operand lookup with write-back bypass
//   wb_valid, wb_idx, wb_value        packed write-back channels, port k at slot k
//   head_idx                          tag of the oldest entry
//   rf_we, rf_rd, rf_value, rf_tag    register commit
//   st_commit, st_ok                  store commit handshake with the LSB
//   flush, flush_pc                   mispredict redirect pulse
module rob_multiport #(
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned WB_PORTS = 3,
    parameter int unsigned XLEN     = 32
) (
    input  logic                         clk_in,
    input  logic                         rst_n_in,
    input  logic                         rdy_in,
    input  logic                         iss_valid,
    input  logic                         iss_ready,
    input  logic [1:0]                   iss_type,
    input  logic [XLEN-1:0]              iss_value,
    input  logic [4:0]                   iss_rd,
    output logic [IDX_W-1:0]             iss_idx,
    output logic                         full,
    output logic                         empty,
    output logic [IDX_W:0]               count,
    input  logic [IDX_W-1:0]             q_idx1,
    input  logic [IDX_W-1:0]             q_idx2,
    output logic                         q_ready1,
    output logic                         q_ready2,
    output logic [XLEN-1:0]              q_value1,
    output logic [XLEN-1:0]              q_value2,
    input  logic [WB_PORTS-1:0]          wb_valid,
    input  logic [WB_PORTS*IDX_W-1:0]    wb_idx,
    input  logic [WB_PORTS*XLEN-1:0]     wb_value,
    output logic [IDX_W-1:0]             head_idx,
    output logic                         rf_we,
    output logic [4:0]                   rf_rd,
    output logic [XLEN-1:0]              rf_value,
    output logic [IDX_W-1:0]             rf_tag,
    output logic                         st_commit,
    input  logic                         st_ok,
    output logic                         flush,
    output logic [XLEN-1:0]              flush_pc
);

    localparam int unsigned     DEPTH     = 2 ** IDX_W;
    localparam logic [IDX_W:0]  DEPTH_CNT = (IDX_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        TYPE_RG  = 2'd0,
        TYPE_ST  = 2'd1,
        TYPE_BR  = 2'd2,
        TYPE_RSV = 2'd3
    } entry_type_e;

    logic [IDX_W-1:0]  head;
    logic [IDX_W-1:0]  tail;
    logic [IDX_W:0]    cnt;
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  ready;
    logic [DEPTH-1:0]  mispred;
    entry_type_e       etype [DEPTH];
    logic [XLEN-1:0]   value [DEPTH];
    logic [4:0]        rd    [DEPTH];
    logic              flush_q;
    logic [XLEN-1:0]   flush_pc_q;

    logic [IDX_W-1:0]  wb_tag  [WB_PORTS];
    logic [XLEN-1:0]   wb_data [WB_PORTS];
    logic [WB_PORTS-1:0] wb_eff;

    logic [IDX_W-1:0]  q_tag  [2];
    logic [1:0]        q_hit;
    logic [XLEN-1:0]   q_data [2];

    entry_type_e       head_type;
    logic              head_live;
    logic              do_issue;
    logic              do_commit;

    always_comb begin
        for (int unsigned k = 0; k < WB_PORTS; k++) begin
            wb_tag[k]  = wb_idx[k*IDX_W +: IDX_W];
            wb_data[k] = wb_value[k*XLEN +: XLEN];
        end
    end

    // A port is effective only if its target is busy and no lower-numbered
    // valid port names the same tag; effective ports therefore never collide.
    always_comb begin
        wb_eff = '0;
        for (int unsigned k = 0; k < WB_PORTS; k++) begin
            wb_eff[k] = wb_valid[k] && busy[wb_tag[k]];
            for (int unsigned j = 0; j < k; j++) begin
                if (wb_valid[j] && (wb_tag[j] == wb_tag[k])) begin
                    wb_eff[k] = 1'b0;
                end
            end
        end
    end

    assign q_tag[0] = q_idx1;
    assign q_tag[1] = q_idx2;

    // Stored value first, otherwise the lowest-numbered matching write-back.
    always_comb begin
        q_hit = '0;
        for (int unsigned p = 0; p < 2; p++) begin
            q_data[p] = '0;
            if (ready[q_tag[p]]) begin
                q_hit[p]  = 1'b1;
                q_data[p] = value[q_tag[p]];
            end else begin
                for (int unsigned k = 0; k < WB_PORTS; k++) begin
                    if (!q_hit[p] && wb_valid[k] && (wb_tag[k] == q_tag[p])) begin
                        q_hit[p]  = 1'b1;
                        q_data[p] = wb_data[k];
                    end
                end
            end
        end
    end

    assign q_ready1 = q_hit[0];
    assign q_ready2 = q_hit[1];
    assign q_value1 = q_data[0];
    assign q_value2 = q_data[1];

    assign head_type = etype[head];
    assign head_live = busy[head] && ready[head];
    assign full      = (cnt == DEPTH_CNT);
    assign empty     = (cnt == '0);
    assign count     = cnt;
    assign iss_idx   = tail;
    assign head_idx  = head;
    assign flush     = flush_q;
    assign flush_pc  = flush_pc_q;

    // Full is sampled before this cycle's commit, so a full buffer never
    // refills in the same cycle it drains.
    assign do_issue  = rdy_in && iss_valid && !full && !flush_q;
    assign do_commit = rdy_in && head_live && !flush_q &&
                       ((head_type != TYPE_ST) || st_ok);

    assign rf_we     = do_commit && (head_type == TYPE_RG);
    assign rf_rd     = rf_we ? rd[head]    : '0;
    assign rf_value  = rf_we ? value[head] : '0;
    assign rf_tag    = rf_we ? head        : '0;
    assign st_commit = head_live && (head_type == TYPE_ST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            head       <= '0;
            tail       <= '0;
            cnt        <= '0;
            busy       <= '0;
            ready      <= '0;
            mispred    <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                etype[i] <= TYPE_RG;
                value[i] <= '0;
                rd[i]    <= '0;
            end
        end else if (rdy_in) begin
            if (flush_q) begin
                busy    <= '0;
                ready   <= '0;
                head    <= '0;
                tail    <= '0;
                cnt     <= '0;
                flush_q <= 1'b0;
            end else begin
                for (int unsigned k = 0; k < WB_PORTS; k++) begin
                    if (wb_eff[k]) begin
                        ready[wb_tag[k]] <= 1'b1;
                        if (etype[wb_tag[k]] == TYPE_BR) begin
                            mispred[wb_tag[k]] <= wb_data[k][0];
                        end else begin
                            value[wb_tag[k]] <= wb_data[k];
                        end
                    end
                end

                if (do_issue) begin
                    busy[tail]    <= 1'b1;
                    ready[tail]   <= iss_ready;
                    mispred[tail] <= 1'b0;
                    etype[tail]   <= entry_type_e'(iss_type);
                    value[tail]   <= iss_value;
                    rd[tail]      <= iss_rd;
                    tail          <= tail + 1'b1;
                end

                if (do_commit) begin
                    busy[head] <= 1'b0;
                    head       <= head + 1'b1;
                    if ((head_type == TYPE_BR) && mispred[head]) begin
                        flush_q    <= 1'b1;
                        flush_pc_q <= value[head];
                    end
                end

                case ({do_issue, do_commit})
                    2'b10:   cnt <= cnt + 1'b1;
                    2'b01:   cnt <= cnt - 1'b1;
                    default: cnt <= cnt;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rob_multiport.sv
module tb_rob_multiport;

    localparam int IDX_W = 4;
    localparam int WB    = 3;
    localparam int XLEN  = 32;
    localparam int DEPTH = 16;

    logic                   clk_in = 1'b0;
    logic                   rst_n_in;
    logic                   rdy_in;
    logic                   iss_valid;
    logic                   iss_ready;
    logic [1:0]             iss_type;
    logic [XLEN-1:0]        iss_value;
    logic [4:0]             iss_rd;
    logic [IDX_W-1:0]       iss_idx;
    logic                   full;
    logic                   empty;
    logic [IDX_W:0]         count;
    logic [IDX_W-1:0]       q_idx1;
    logic [IDX_W-1:0]       q_idx2;
    logic                   q_ready1;
    logic                   q_ready2;
    logic [XLEN-1:0]        q_value1;
    logic [XLEN-1:0]        q_value2;
    logic [WB-1:0]          wb_valid;
    logic [WB*IDX_W-1:0]    wb_idx;
    logic [WB*XLEN-1:0]     wb_value;
    logic [IDX_W-1:0]       head_idx;
    logic                   rf_we;
    logic [4:0]             rf_rd;
    logic [XLEN-1:0]        rf_value;
    logic [IDX_W-1:0]       rf_tag;
    logic                   st_commit;
    logic                   st_ok;
    logic                   flush;
    logic [XLEN-1:0]        flush_pc;

    rob_multiport #(.IDX_W(IDX_W), .WB_PORTS(WB), .XLEN(XLEN)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_type(iss_type),
        .iss_value(iss_value), .iss_rd(iss_rd), .iss_idx(iss_idx),
        .full(full), .empty(empty), .count(count),
        .q_idx1(q_idx1), .q_idx2(q_idx2), .q_ready1(q_ready1), .q_ready2(q_ready2),
        .q_value1(q_value1), .q_value2(q_value2),
        .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_value(wb_value),
        .head_idx(head_idx), .rf_we(rf_we), .rf_rd(rf_rd), .rf_value(rf_value),
        .rf_tag(rf_tag), .st_commit(st_commit), .st_ok(st_ok),
        .flush(flush), .flush_pc(flush_pc)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: live entries kept oldest-first in a queue; tags are
    // consecutive from m_head. Retired entries leave their value visible to
    // queries until a flush or reset.
    typedef struct {
        int              tag;
        bit              rdy;
        int              typ;
        logic [XLEN-1:0] val;
        logic [4:0]      rd;
        bit              mis;
    } ent_t;

    ent_t            rob[$];
    int              m_head;
    bit              m_flush;
    logic [XLEN-1:0] m_fpc;
    bit              last_rdy[DEPTH];
    logic [XLEN-1:0] last_val[DEPTH];

    int              obs_rd[$];
    logic [XLEN-1:0] obs_val[$];

    function automatic void model_reset();
        rob.delete();
        m_head  = 0;
        m_flush = 0;
        m_fpc   = '0;
        for (int t = 0; t < DEPTH; t++) begin
            last_rdy[t] = 0;
            last_val[t] = '0;
        end
    endfunction

    function automatic int find_tag(input int t);
        foreach (rob[i]) if (rob[i].tag == t) return i;
        return -1;
    endfunction

    function automatic int wb_tag_of(input int k);
        logic [IDX_W-1:0] t;
        t = wb_idx[k*IDX_W +: IDX_W];
        return int'(t);
    endfunction

    function automatic logic [XLEN-1:0] wb_val_of(input int k);
        return wb_value[k*XLEN +: XLEN];
    endfunction

    function automatic void exp_query(input int t, output bit r, output logic [XLEN-1:0] v);
        int i;
        i = find_tag(t);
        r = 0;
        v = '0;
        if (i >= 0 ? rob[i].rdy : last_rdy[t]) begin
            r = 1;
            v = (i >= 0) ? rob[i].val : last_val[t];
            return;
        end
        for (int k = 0; k < WB; k++) begin
            if (wb_valid[k] && wb_tag_of(k) == t) begin
                r = 1;
                v = wb_val_of(k);
                return;
            end
        end
    endfunction

    task automatic idle();
        rdy_in    = 1'b1;
        iss_valid = 1'b0;
        iss_ready = 1'b0;
        iss_type  = 2'd0;
        iss_value = '0;
        iss_rd    = '0;
        wb_valid  = '0;
        wb_idx    = '0;
        wb_value  = '0;
        st_ok     = 1'b0;
        q_idx1    = '0;
        q_idx2    = '0;
    endtask

    task automatic set_wb(input int k, input int tag, input logic [XLEN-1:0] v);
        wb_valid[k]                = 1'b1;
        wb_idx[k*IDX_W +: IDX_W]   = IDX_W'(tag);
        wb_value[k*XLEN +: XLEN]   = v;
    endtask

    // Called at a negedge with inputs driven: checks outputs, advances the
    // model, and returns at the following negedge.
    task automatic cycle();
        int              sz;
        int              tl;
        bit              ec;
        bit              ewe;
        bit              est;
        bit              qr;
        bit              claimed[DEPTH];
        logic [XLEN-1:0] qv;
        ent_t            f;
        ent_t            e;
        int              i;
        int              t;
        #1;
        sz = rob.size();
        tl = (m_head + sz) % DEPTH;
        f  = '{tag: 0, rdy: 0, typ: 0, val: '0, rd: '0, mis: 0};
        if (sz > 0) f = rob[0];
        ec  = rdy_in && sz > 0 && f.rdy && !m_flush && (f.typ != 1 || st_ok);
        ewe = ec && f.typ == 0;
        est = sz > 0 && f.rdy && f.typ == 1;
        check_eq("full",      64'(full),      64'(sz == DEPTH));
        check_eq("empty",     64'(empty),     64'(sz == 0));
        check_eq("count",     64'(count),     64'(sz));
        check_eq("iss_idx",   64'(iss_idx),   64'(tl));
        check_eq("head_idx",  64'(head_idx),  64'(m_head));
        check_eq("flush",     64'(flush),     64'(m_flush));
        if (m_flush) check_eq("flush_pc", 64'(flush_pc), 64'(m_fpc));
        check_eq("st_commit", 64'(st_commit), 64'(est));
        if (rdy_in) begin
            check_eq("rf_we",    64'(rf_we),    64'(ewe));
            check_eq("rf_rd",    64'(rf_rd),    ewe ? 64'(f.rd)  : 64'd0);
            check_eq("rf_value", 64'(rf_value), ewe ? 64'(f.val) : 64'd0);
            check_eq("rf_tag",   64'(rf_tag),   ewe ? 64'(f.tag) : 64'd0);
            if (rf_we) begin
                obs_rd.push_back(int'(rf_rd));
                obs_val.push_back(rf_value);
            end
        end
        exp_query(int'(q_idx1), qr, qv);
        check_eq("q_ready1", 64'(q_ready1), 64'(qr));
        check_eq("q_value1", 64'(q_value1), 64'(qv));
        exp_query(int'(q_idx2), qr, qv);
        check_eq("q_ready2", 64'(q_ready2), 64'(qr));
        check_eq("q_value2", 64'(q_value2), 64'(qv));

        if (rdy_in) begin
            if (m_flush) begin
                rob.delete();
                m_head  = 0;
                m_flush = 0;
                for (int j = 0; j < DEPTH; j++) last_rdy[j] = 0;
            end else begin
                for (int j = 0; j < DEPTH; j++) claimed[j] = 0;
                for (int k = 0; k < WB; k++) begin
                    t = wb_tag_of(k);
                    if (wb_valid[k] && !claimed[t]) begin
                        claimed[t] = 1;
                        i = find_tag(t);
                        if (i >= 0) begin
                            rob[i].rdy = 1;
                            if (rob[i].typ == 2) rob[i].mis = wb_val_of(k)[0];
                            else rob[i].val = wb_val_of(k);
                        end
                    end
                end
                if (ec) begin
                    e = rob.pop_front();
                    last_rdy[e.tag] = 1;
                    last_val[e.tag] = e.val;
                    m_head = (m_head + 1) % DEPTH;
                    if (f.typ == 2 && f.mis) begin
                        m_flush = 1;
                        m_fpc   = f.val;
                    end
                end
                if (iss_valid && sz < DEPTH) begin
                    rob.push_back('{tag: tl, rdy: iss_ready, typ: int'(iss_type),
                                    val: iss_value, rd: iss_rd, mis: 0});
                end
            end
        end
        @(posedge clk_in);
        @(negedge clk_in);
    endtask

    task automatic issue(input logic [1:0] ty, input bit r, input logic [XLEN-1:0] v, input logic [4:0] rdv);
        idle();
        iss_valid = 1'b1;
        iss_type  = ty;
        iss_ready = r;
        iss_value = v;
        iss_rd    = rdv;
        cycle();
    endtask

    task automatic apply_reset();
        idle();
        rst_n_in = 1'b0;
        #2;
        rst_n_in = 1'b1;
        model_reset();
        @(negedge clk_in);
    endtask

    initial begin
        int r;
        int sz;
        idle();
        rst_n_in = 1'b0;
        model_reset();
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(negedge clk_in);

        // Out-of-order write-back, in-order register commit
        obs_rd.delete();
        obs_val.delete();
        for (int i = 1; i <= 3; i++) issue(2'd0, 1'b0, '0, 5'(i));
        idle(); set_wb(0, 2, 32'h11); cycle();
        idle(); set_wb(0, 0, 32'h22); cycle();
        idle(); set_wb(0, 1, 32'h33); cycle();
        for (int i = 0; i < 3; i++) begin idle(); cycle(); end
        check_eq("commit_n", 64'(obs_rd.size()), 64'd3);
        if (obs_rd.size() == 3) begin
            check_eq("commit0_rd",  64'(obs_rd[0]),  64'd1);
            check_eq("commit0_val", 64'(obs_val[0]), 64'h22);
            check_eq("commit1_rd",  64'(obs_rd[1]),  64'd2);
            check_eq("commit1_val", 64'(obs_val[1]), 64'h33);
            check_eq("commit2_rd",  64'(obs_rd[2]),  64'd3);
            check_eq("commit2_val", 64'(obs_val[2]), 64'h11);
        end

        // Fill to DEPTH, drop the overflow issue, then drain one
        apply_reset();
        for (int i = 0; i < DEPTH; i++) issue(2'd0, 1'b0, 32'(i), 5'(i));
        idle(); #1;
        check_eq("fill_full",  64'(full),  64'd1);
        check_eq("fill_count", 64'(count), 64'd16);
        check_eq("fill_empty", 64'(empty), 64'd0);
        issue(2'd0, 1'b1, 32'hDEAD, 5'd9);
        idle(); #1;
        check_eq("drop_count", 64'(count),   64'd16);
        check_eq("drop_tail",  64'(iss_idx), 64'd0);
        idle(); set_wb(0, 0, 32'h5); cycle();
        idle(); cycle();
        idle(); #1;
        check_eq("drain_full",  64'(full),  64'd0);
        check_eq("drain_count", 64'(count), 64'd15);

        // Store held at head until the LSB acknowledges
        apply_reset();
        issue(2'd1, 1'b1, 32'h0, 5'd0);
        for (int i = 0; i < 5; i++) begin
            idle(); #1;
            check_eq("st_hold",      64'(st_commit), 64'd1);
            check_eq("st_hold_head", 64'(head_idx),  64'd0);
            cycle();
        end
        idle(); st_ok = 1'b1; cycle();
        idle(); #1;
        check_eq("st_done",      64'(st_commit), 64'd0);
        check_eq("st_done_head", 64'(head_idx),  64'd1);

        // Mispredicted branch flushes younger entries
        apply_reset();
        issue(2'd2, 1'b0, 32'h1000, 5'd0);
        issue(2'd0, 1'b0, 32'h0, 5'd4);
        issue(2'd0, 1'b0, 32'h0, 5'd5);
        idle(); set_wb(0, 0, 32'h1); cycle();
        idle(); cycle();
        idle(); set_wb(1, 1, 32'h55); #1;
        check_eq("br_flush",    64'(flush),    64'd1);
        check_eq("br_flush_pc", 64'(flush_pc), 64'h1000);
        check_eq("br_no_rf",    64'(rf_we),    64'd0);
        cycle();
        idle(); #1;
        check_eq("post_flush",       64'(flush),    64'd0);
        check_eq("post_flush_count", 64'(count),    64'd0);
        check_eq("post_flush_head",  64'(head_idx), 64'd0);
        check_eq("post_flush_tail",  64'(iss_idx),  64'd0);

        // Same-tag write-back on two ports: lowest port wins
        apply_reset();
        for (int i = 0; i < 6; i++) issue(2'd0, 1'b0, '0, 5'(i + 1));
        idle(); set_wb(0, 5, 32'hAA); set_wb(2, 5, 32'hBB); q_idx1 = 4'd5; #1;
        check_eq("byp_ready", 64'(q_ready1), 64'd1);
        check_eq("byp_value", 64'(q_value1), 64'hAA);
        cycle();
        idle(); q_idx1 = 4'd5; #1;
        check_eq("stored_ready", 64'(q_ready1), 64'd1);
        check_eq("stored_value", 64'(q_value1), 64'hAA);
        cycle();

        // Randomised traffic against the model
        apply_reset();
        for (int n = 0; n < 1500; n++) begin
            idle();
            rdy_in    = ($urandom_range(0, 9) != 0);
            iss_valid = ($urandom_range(0, 9) < 6);
            iss_ready = ($urandom_range(0, 9) < 3);
            r = $urandom_range(0, 19);
            iss_type  = (r < 12) ? 2'd0 : (r < 18) ? 2'd1 : 2'd2;
            iss_value = $urandom;
            iss_rd    = 5'($urandom);
            st_ok     = $urandom_range(0, 1);
            q_idx1    = 4'($urandom);
            q_idx2    = 4'($urandom);
            sz = rob.size();
            for (int k = 0; k < WB; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    set_wb(k, (sz > 0 && $urandom_range(0, 4) != 0) ?
                              rob[$urandom_range(0, sz - 1)].tag : int'($urandom_range(0, DEPTH - 1)),
                           $urandom);
                end
            end
            cycle();
        end

        // Asynchronous reset with rdy_in low, between clock edges
        idle();
        for (int i = 0; i < 4; i++) issue(2'd1, 1'b1, 32'h7, 5'd1);
        idle();
        rdy_in = 1'b0;
        #2;
        rst_n_in = 1'b0;
        #1;
        check_eq("arst_full",      64'(full),      64'd0);
        check_eq("arst_empty",     64'(empty),     64'd1);
        check_eq("arst_count",     64'(count),     64'd0);
        check_eq("arst_rf_we",     64'(rf_we),     64'd0);
        check_eq("arst_st_commit", 64'(st_commit), 64'd0);
        check_eq("arst_flush",     64'(flush),     64'd0);
        check_eq("arst_head",      64'(head_idx),  64'd0);
        check_eq("arst_tail",      64'(iss_idx),   64'd0);
        model_reset();
        #1;
        rst_n_in = 1'b1;
        @(negedge clk_in);
        for (int i = 0; i < 3; i++) begin idle(); cycle(); end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rob_multiport.md
Name: rob_multiport

Overview:
- Parametrised reorder buffer, successor to the single-write-back ROB.
- Sits between decoder (issue), execution units (N write-back channels), register file (commit) and LSB (store commit).
- Adds:
  - configurable depth and write-back port count;
  - count-based full/empty, so a full buffer is never aliased as empty;
  - explicit store-commit handshake;
  - occupancy output;
  - registered one-cycle flush on branch mispredict.

Parameters:
- IDX_W, 4, ROB index width; DEPTH = 2^IDX_W entries.
- WB_PORTS, 3, number of write-back channels (ALU, LSB, spare).
- XLEN, 32, data/address width.

Ports:
- clk_in  input  1  system clock; all state changes on posedge.
- rst_n_in  input  1  asynchronous reset, active-low.
- rdy_in  input  1  global ready; low freezes all state.
- iss_valid  input  1  issue request.
- iss_ready  input  1  entry result already known at issue.
- iss_type  input  2  entry type: 0=RG, 1=ST, 2=BR.
- iss_value  input  XLEN  result (RG) or alternate PC (BR).
- iss_rd  input  5  destination register.
- iss_idx  output  IDX_W  tag given to the issuing entry (= tail).
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- count  output  IDX_W+1  occupancy.
- q_idx1, q_idx2  input  IDX_W  operand query tags.
- q_ready1, q_ready2  output  1  queried value available.
- q_value1, q_value2  output  XLEN  queried value.
- wb_valid  input  WB_PORTS  per-port write-back strobe.
- wb_idx  input  WB_PORTS*IDX_W  packed tags; port k at bits [k*IDX_W +: IDX_W].
- wb_value  input  WB_PORTS*XLEN  packed results.
- head_idx  output  IDX_W  tag of oldest entry.
- rf_we  output  1  register commit this cycle.
- rf_rd  output  5  destination register of the commit.
- rf_value  output  XLEN  committed value.
- rf_tag  output  IDX_W  tag of the committing entry.
- st_commit  output  1  head is a ready store awaiting the LSB.
- st_ok  input  1  LSB has performed the head store.
- flush  output  1  registered mispredict flush pulse.
- flush_pc  output  XLEN  redirect PC, valid while flush is high.

Behaviour:
- Reset (async, rst_n_in low):
  - head, tail, count = 0;
  - all busy/ready bits = 0;
  - flush = 0, flush_pc = 0.
  - Outputs during reset: rf_we=0, st_commit=0, full=0, empty=1.
  - Reset mid-flush or mid-store discards everything; no commit occurs.
- rdy_in low: no state change; combinational outputs still reflect current state.
- Issue:
  - Accepted when iss_valid && !full && !flush.
  - Writes entry[tail]: busy=1, ready=iss_ready, plus type/value/rd.
  - tail wraps modulo DEPTH.
  - iss_valid while full is dropped; the decoder must stall on full.
- Write-back, for each port k with wb_valid[k] and busy[wb_idx_k]:
  - ready=1.
  - RG/ST: value=wb_value.
  - BR: mispred bit = wb_value[0]; value (the alternate PC) is kept.
  - A write-back to a non-busy entry is ignored.
  - Several ports hitting the same tag: lowest k wins.
- Commit decision:
  - commit = busy[head] && ready[head] && !flush && (type != ST || st_ok).
  - Uses registered state only; a write-back to head commits one cycle later at the earliest.
  - On commit: busy[head]=0, head+1, count-1.
- Register commit:
  - rf_we = commit && type==RG.
  - rf_rd, rf_value, rf_tag come from head; all are 0 when rf_we=0.
- Store commit:
  - st_commit = busy && ready && type==ST at head, held until st_ok.
  - st_ok without st_commit is ignored.
- Branch commit:
  - BR with mispred=1 sets flush<=1 and flush_pc<=value[head].
  - BR with mispred=0 retires silently.
- Flush:
  - The cycle after flush goes high (with rdy_in): clear all busy/ready, head=tail=count=0, flush<=0.
  - While flush=1: issue, write-back and commit are all ignored.
- Count:
  - Issue-only: +1. Commit-only: -1. Both in the same cycle: unchanged.
  - Issue into a full buffer is blocked even if the head commits that cycle; no same-cycle refill.
- Query bypass, per query port:
  - If ready[q]: q_value = stored value.
  - Else the lowest-k wb port with wb_valid && wb_idx==q supplies the value.
  - q_ready = either condition.
  - If neither: q_ready=0, q_value=0.

Test Plan:
- Reset, then issue 3 RG entries (rd=1,2,3), write back values 0x11/0x22/0x33 out of order (tags 2, 0, 1) -> rf_we pulses in tag order 0, 1, 2 with rf_rd=1, 2, 3 and values 0x22, 0x33, 0x11.
- Issue DEPTH=16 entries with no commit -> full=1, count=16, empty=0; a 17th iss_valid is dropped and tail stays 0; one commit -> full=0, count=15.
- ST at head, ready, st_ok held low 5 cycles -> st_commit=1 throughout, head unchanged; st_ok=1 -> head advances next edge, st_commit=0.
- BR (iss_value=0x1000) followed by 2 RG entries; wb BR with wb_value[0]=1 -> commit yields flush=1 and flush_pc=0x1000 for one cycle; then count=0, head=tail=0, and a younger RG write-back during flush produces no rf_we.
- Ports 0 and 2 write tag 5 in the same cycle (0xAA, 0xBB) while q_idx1=5 -> q_ready1=1, q_value1=0xAA combinationally; entry 5 stores 0xAA.
- Async rst_n_in low mid-stream with rdy_in=0 -> all outputs at reset values immediately, with no clock edge required.
